// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit 7-segment driver for an MM:SS stopwatch display.
// Scans one digit per SCAN_DIV-cycle slot with a blanked lead-in against
// ghosting, shows digits from a frame-aligned snapshot so a frame never
// mixes old and new counter values, and blinks the colon (dp of digit 2)
// while the stopwatch runs. All outputs are registered and active-low.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic       running,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned SCW = $clog2(SCAN_DIV);
  localparam int unsigned BKW = $clog2(BLINK_DIV);

  localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
  localparam logic [SCW-1:0] BLANK_END  = SCW'(BLANK_CYC);
  localparam logic [BKW-1:0] BLINK_LAST = BKW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    case (d)
      4'd0:    decode_digit = 7'h40;
      4'd1:    decode_digit = 7'h79;
      4'd2:    decode_digit = 7'h24;
      4'd3:    decode_digit = 7'h30;
      4'd4:    decode_digit = 7'h19;
      4'd5:    decode_digit = 7'h12;
      4'd6:    decode_digit = 7'h02;
      4'd7:    decode_digit = 7'h78;
      4'd8:    decode_digit = 7'h00;
      4'd9:    decode_digit = 7'h10;
      default: decode_digit = SEG_DASH;
    endcase
  endfunction

  logic [SCW-1:0]  scan_cnt_q;
  logic [1:0]      idx_q;
  logic [BKW-1:0]  blink_cnt_q;
  logic            blink_q;
  logic [3:0][3:0] snap_q;       // [0]=sec_ones .. [3]=min_tens
  logic            frame_tick_q;
  logic [3:0]      an_q,  an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q,  dp_d;

  logic slot_end;
  logic frame_wrap;

  assign slot_end   = (scan_cnt_q == SCAN_LAST);
  assign frame_wrap = slot_end && (idx_q == 2'd3);

  // Slot timer and digit index; the index advances on the last cycle of a slot.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
    end else if (slot_end) begin
      scan_cnt_q <= '0;
      idx_q      <= idx_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + SCW'(1);
    end
  end

  // Frame snapshot of the input digits, taken as idx wraps 3->0.
  // NOTE: the snapshot is reset (not left uninitialised like a RAM) because
  // the first frame after reset must display zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q       <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_wrap;
      if (frame_wrap) begin
        snap_q <= {min_tens, min_ones, sec_tens, sec_ones};
      end
    end
  end

  // Free-running colon blink phase, independent of the run status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BKW'(1);
    end
  end

  // Next display state from slot position, snapshot and live run/blank inputs.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((scan_cnt_q >= BLANK_END) &&
        !((idx_q == 2'd3) && blank_lz && (snap_q[3] == 4'd0))) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode_digit(snap_q[idx_q]);
      dp_d  = !((idx_q == 2'd2) && (!running || blink_q));
    end
  end

  // Registered pad drivers: one cycle behind the scan state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 4'hF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with short scan/blink periods.
// A reference model derives the expected display from the number of clock
// edges since reset release using plain arithmetic on slot/frame positions.
module tb_seg7_scan_driver;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int BD    = 20;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sec_ones = '0, sec_tens = '0, min_ones = '0, min_tens = '0;
  logic       running = 1'b0, blank_lz = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .running    (running),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h3F;
    endcase
  endfunction

  // Reference model: k = clock edges taken since reset release.
  int         k = 0;
  int         m_pos, m_cnt, m_slot;
  logic [3:0] m_snap [4] = '{default: 4'd0};
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1, e_tick = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k = 0;
      m_snap = '{default: 4'd0};
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
    end else begin
      m_pos  = k;
      m_cnt  = m_pos % SD;
      m_slot = (m_pos / SD) % 4;
      if (m_cnt < BC || (m_slot == 3 && blank_lz && m_snap[3] == 4'd0)) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = 4'hF & ~(4'b0001 << m_slot);
        e_seg = seg_ref(m_snap[m_slot]);
        e_dp  = !(m_slot == 2 && (!running || ((m_pos / BD) % 2 == 1)));
      end
      e_tick = (m_pos % FRAME == FRAME - 1);
      if (e_tick) m_snap = '{sec_ones, sec_tens, min_ones, min_tens};
      k = k + 1;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_state an=%h seg=%h dp=%b tick=%b required F/7F/1/0",
                 an, seg, dp, frame_tick);
      end
    end
  endtask

  task automatic test_first_frames();
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] exp_seg [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
    sec_ones = 4'd1; sec_tens = 4'd2; min_ones = 4'd3; min_tens = 4'd4;
    running = 1'b0; blank_lz = 1'b0;
    reset_n = 1'b1;
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick} || $countones(~an) > 1) begin
        errors++;
        $display("FAIL first_frames c=%0d an=%h seg=%h dp=%b tick=%b required %h/%h/%b/%b",
                 c, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      if (c == FRAME) begin
        checks++;
        if (frame_tick !== 1'b1) begin
          errors++;
          $display("FAIL frame_tick_at_32 tick=%b required 1", frame_tick);
        end
      end
      if (c % SD == 5) begin
        checks++;
        if (c < FRAME ? (an !== exp_an[c / SD] || seg !== 7'h40)
                      : (an !== exp_an[(c - FRAME) / SD] || seg !== exp_seg[(c - FRAME) / SD])) begin
          errors++;
          $display("FAIL frame_digits c=%0d an=%h seg=%h", c, an, seg);
        end
      end
    end
  endtask

  task automatic test_snapshot_hold();
    bit tick_seen = 0;
    for (int g = 0; g < 2 * FRAME && (k % FRAME) != 4; g++) @(negedge clk);
    sec_ones = 4'd5;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL snapshot_model k=%0d an=%h seg=%h required %h/%h", k, an, seg, e_an, e_seg);
      end
      if (an === 4'hE) begin
        checks++;
        if (seg !== (tick_seen ? 7'h12 : 7'h79)) begin
          errors++;
          $display("FAIL snapshot_hold seg=%h required %h", seg, tick_seen ? 7'h12 : 7'h79);
        end
      end
      if (frame_tick) tick_seen = 1;
    end
  endtask

  task automatic test_blank_lz();
    int lit;
    for (int g = 0; g < 2 * FRAME && (k % FRAME) != 0; g++) @(negedge clk);
    min_tens = 4'd0; blank_lz = 1'b1;
    for (int phase = 0; phase < 6; phase++) begin
      if (phase == 2) blank_lz = 1'b0;
      if (phase == 3) min_tens = 4'hC;
      lit = 0;
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        checks++;
        if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
          errors++;
          $display("FAIL blank_lz_model k=%0d an=%h seg=%h required %h/%h", k, an, seg, e_an, e_seg);
        end
        if ((k - 1) % FRAME >= 3 * SD && an !== 4'hF) lit++;
        if ((k - 1) % FRAME == 3 * SD + 5 && (phase == 2 || phase == 4)) begin
          checks++;
          if (an !== 4'h7 || seg !== (phase == 2 ? 7'h40 : 7'h3F)) begin
            errors++;
            $display("FAIL min_tens_shown phase=%0d an=%h seg=%h", phase, an, seg);
          end
        end
      end
      if (phase == 1) begin
        checks++;
        if (lit != 0) begin
          errors++;
          $display("FAIL leading_zero_blank lit_cycles=%0d required 0", lit);
        end
      end
    end
  endtask

  task automatic test_blink();
    int dp_low, dp_high;
    running = 1'b1; dp_low = 0; dp_high = 0;
    for (int c = 0; c < 8 * BD; c++) begin
      if (c == 6 * BD) running = 1'b0;
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL blink k=%0d running=%b dp=%b required %b", k, running, dp, e_dp);
      end
      if (c < 6 * BD && an === 4'hB) begin
        if (dp) dp_high++; else dp_low++;
      end
    end
    checks++;
    if (dp_low == 0 || dp_high == 0) begin
      errors++;
      $display("FAIL blink_phases low=%0d high=%0d required both nonzero", dp_low, dp_high);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick} || $countones(~an) > 1) begin
        errors++;
        $display("FAIL random k=%0d an=%h seg=%h dp=%b tick=%b required %h/%h/%b/%b",
                 k, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_tick);
      end
      if ($urandom_range(7) == 0) begin
        sec_ones = 4'($urandom_range(15)); sec_tens = 4'($urandom_range(15));
        min_ones = 4'($urandom_range(15)); min_tens = 4'($urandom_range(3));
      end
      if ($urandom_range(15) == 0) running = ~running;
      if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
    end
  endtask

  task automatic test_async_reset();
    for (int g = 0; g < 2 * FRAME && (k % FRAME) != 2 * SD + 5; g++) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset an=%h seg=%h dp=%b tick=%b required F/7F/1/0",
               an, seg, dp, frame_tick);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= FRAME + 4; c++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, dp, frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
        errors++;
        $display("FAIL restart_model c=%0d an=%h seg=%h required %h/%h", c, an, seg, e_an, e_seg);
      end
      if (c == 1 || c == 3) begin
        checks++;
        if (an !== (c == 1 ? 4'hF : 4'hE)) begin
          errors++;
          $display("FAIL restart_slot0 c=%0d an=%h required %h", c, an, c == 1 ? 4'hF : 4'hE);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frames();
    test_snapshot_hold();
    test_blank_lz();
    test_blink();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot (1 kHz slot rate at 50 MHz); legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 16, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 1..SCAN_DIV-2.
REQ-003 Parameter BLINK_DIV, default 25000000, cycles per colon blink half-period; legal range 2..2^26.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low; release is synchronous to clk.
REQ-006 sec_ones, sec_tens, min_ones, min_tens  input  4 each  BCD digits from the upstream stopwatch counter.
REQ-007 running  input  1  stopwatch run status (the start_stop level); 1 = colon blinks, 0 = colon steady on.
REQ-008 blank_lz  input  1  1 = blank min_tens when it is 0.
REQ-009 an  output  4  digit anodes, active-low; an[0]=sec_ones, an[1]=sec_tens, an[2]=min_ones, an[3]=min_tens.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point / colon, active-low.
REQ-012 frame_tick  output  1  one-cycle pulse at each snapshot.

Function
REQ-013 Scan counter scan_cnt SHALL count 0..SCAN_DIV-1 and wrap; the edge at scan_cnt==SCAN_DIV-1 SHALL advance digit index idx (0,1,2,3,0,...).
REQ-014 On the edge where idx wraps 3->0, all four input digits SHALL be captured into snapshot registers and frame_tick SHALL be 1 for the following cycle; displayed digits SHALL come only from the snapshot, so one frame never mixes old and new values.
REQ-015 an, seg and dp SHALL be registered and reflect (idx, scan_cnt, snapshot) with exactly one cycle latency.
REQ-016 While scan_cnt < BLANK_CYC: an=4'hF, seg=7'h7F, dp=1; otherwise an = active-low one-hot of idx.
REQ-017 Decode (active-low hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10; any code 10..15 SHALL show dash 7'h3F.
REQ-018 When blank_lz=1 and snapshot min_tens==0, slot idx 3 SHALL drive an=4'hF and seg=7'h7F for the full slot; blank_lz is sampled live, not snapshotted.
REQ-019 Blink counter SHALL count 0..BLINK_DIV-1 continuously and toggle phase bit blink on wrap, regardless of running.
REQ-020 dp SHALL be 0 only during the active (non-blank) part of slot idx 2 when (running==0) or (blink==1); dp=1 in all other slots.
REQ-021 A change of running SHALL take effect on dp within one cycle (live input, not snapshotted).
REQ-022 Inputs SHALL be treated as synchronous to clk; no internal synchronisers.

Reset
REQ-023 While reset_n=0: an=4'hF, seg=7'h7F, dp=1, frame_tick=0, scan_cnt=0, idx=0, blink=0, blink counter=0, snapshot=0.
REQ-024 First cycle after release SHALL begin a blanking period of slot 0; snapshot SHALL first load at the first 3->0 wrap, so the first frame shows 0000 (or _000 with blank_lz=1).
REQ-025 Reset asserted mid-slot or mid-frame SHALL force REQ-023 values immediately, without waiting for a clock edge.

Verification (SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=20)
REQ-026 Reset release, digits 1,2,3,4 applied -> first frame shows 0 on all four anodes; frame_tick at cycle 32; second frame shows an=E seg=79, an=D seg=24, an=B seg=30, an=7 seg=19.
REQ-027 Each slot -> first 2 cycles an=F seg=7F, remaining 6 cycles one anode low; no cycle with two anodes low.
REQ-028 sec_ones changed from 1 to 5 mid-frame -> display keeps 79 until after next frame_tick, then 12.
REQ-029 min_tens=0, blank_lz=1 -> slot 3 an=F for all 8 cycles; blank_lz=0 -> an=7 seg=40; min_tens=4'hC -> seg=3F.
REQ-030 running=1 -> dp low in slot 2 only when blink=1 (20-cycle phases); running=0 -> dp low in every active slot-2 cycle.
REQ-031 reset_n pulled low at scan_cnt=5 of slot 2 -> outputs go to REQ-023 values asynchronously; after release scanning restarts at slot 0.
